// File: rtl/sim_mmio_pkg.sv
// Shared constants and types for the simulation MMIO console: default register
// addresses, status register layout and the putchar stall state encoding.
package sim_mmio_pkg;

   localparam logic [31:0] DEF_PUTCHAR_ADDR = 32'h0000_1000;
   localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1004;
   localparam logic [31:0] DEF_STATUS_ADDR  = 32'h0000_1008;

   // Status register bit positions
   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_EXIT_BIT  = 2;
   localparam int unsigned STAT_OVF_BIT   = 3;
   localparam int unsigned STAT_COUNT_LSB = 8;
   localparam int unsigned STAT_COUNT_W   = 8;

   // A putchar write is force-granted once it has been refused this many cycles
   localparam int unsigned STALL_TIMEOUT = 64;
   localparam int unsigned STALL_CNT_W   = 7;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } stall_state_e;

   // Clamp a count into the 8-bit status field
   function automatic logic [7:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 8'hFF : v[7:0];
   endfunction

endpackage

// File: rtl/sim_mmio_fifo.sv
// Character FIFO with registered full/empty flags; push when full and pop when
// empty are ignored, so callers may drive them unconditionally.
module sim_mmio_fifo
   import sim_mmio_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               data_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               data_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push_c, do_pop_c;

   assign do_push_c = push_i && !full_q;
   assign do_pop_c  = pop_i && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push_c && !do_pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push_c && do_pop_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push_c) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/sim_mmio_console.sv
// Simulation console on the core data bus: putchar into a character FIFO,
// first-exit-wins tohost latch, read-only status, one-cycle response.
module sim_mmio_console
   import sim_mmio_pkg::*;
#(
   parameter logic [31:0] PUTCHAR_ADDR = DEF_PUTCHAR_ADDR,
   parameter logic [31:0] TOHOST_ADDR  = DEF_TOHOST_ADDR,
   parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        char_valid_o,
   input  logic        char_ready_i,
   output logic [7:0]  char_data_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_code_o,
   output logic        overflow_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   stall_state_e           state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   rvalid_q;
   logic [31:0]            rdata_q, rdata_d;
   logic                   exit_valid_q;
   logic [31:0]            exit_code_q;
   logic                   overflow_q;

   logic                   sel_put_c, sel_tohost_c, sel_status_c;
   logic                   put_wr_c, timeout_c;
   logic                   push_c, pop_c, drop_full_c, tohost_wr_c;
   logic [31:0]            status_c;
   logic                   fifo_full, fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic                   unused_addr_lsb;

   assign unused_addr_lsb = ^addr_i[1:0];

   assign sel_put_c    = (addr_i[31:2] == PUTCHAR_ADDR[31:2]);
   assign sel_tohost_c = (addr_i[31:2] == TOHOST_ADDR[31:2]);
   assign sel_status_c = (addr_i[31:2] == STATUS_ADDR[31:2]);

   assign put_wr_c  = req_i && we_i && sel_put_c;
   assign timeout_c = (state_q == ST_STALL) &&
                      (stall_cnt_q >= STALL_CNT_W'(STALL_TIMEOUT));

   // Stall only on the registered full flag; timeout forces the grant through
   assign gnt_o = req_i && !(put_wr_c && fifo_full && !timeout_c);

   assign push_c      = gnt_o && put_wr_c && be_i[0] && !fifo_full;
   assign drop_full_c = gnt_o && put_wr_c && fifo_full;
   assign pop_c       = !fifo_empty && char_ready_i;
   assign tohost_wr_c = gnt_o && we_i && sel_tohost_c && (be_i == 4'hF) &&
                        !exit_valid_q;

   sim_mmio_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_c),
      .data_i  (wdata_i[7:0]),
      .pop_i   (pop_c),
      .data_o  (char_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Stall tracker: the counter holds the number of cycles already refused
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (put_wr_c && fifo_full) begin
               state_d     = ST_STALL;
               stall_cnt_d = STALL_CNT_W'(1);
            end
         end
         ST_STALL: begin
            if (!put_wr_c || gnt_o) begin
               state_d = ST_IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      status_c                                  = '0;
      status_c[STAT_COUNT_LSB +: STAT_COUNT_W]  = sat8(32'(fifo_count));
      status_c[STAT_OVF_BIT]                    = overflow_q;
      status_c[STAT_EXIT_BIT]                   = exit_valid_q;
      status_c[STAT_FULL_BIT]                   = fifo_full;
      status_c[STAT_EMPTY_BIT]                  = fifo_empty;
   end

   always_comb begin
      rdata_d = '0;
      if (gnt_o && !we_i) begin
         if (sel_status_c) begin
            rdata_d = status_c;
         end else if (sel_tohost_c) begin
            rdata_d = exit_code_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         stall_cnt_q  <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         exit_valid_q <= 1'b0;
         exit_code_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         rvalid_q    <= gnt_o;
         rdata_q     <= rdata_d;
         if (tohost_wr_c) begin
            exit_valid_q <= 1'b1;
            exit_code_q  <= wdata_i;
         end
         if (drop_full_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign rvalid_o     = rvalid_q;
   assign rdata_o      = rdata_q;
   assign char_valid_o = !fifo_empty;
   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_sim_mmio_console.sv
// Scoreboard bench for sim_mmio_console: directed bus operations push expected
// responses/characters; a negedge monitor pops and compares them.
module tb_sim_mmio_console;

   localparam logic [31:0] A_PUT  = 32'h0000_1000;
   localparam logic [31:0] A_TOH  = 32'h0000_1004;
   localparam logic [31:0] A_STAT = 32'h0000_1008;
   localparam logic [31:0] A_NONE = 32'h0000_2000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        gnt_o, rvalid_o, char_valid_o, exit_valid_o, overflow_o;
   logic [31:0] rdata_o, exit_code_o;
   logic        char_ready_i = 1'b0;
   logic [7:0]  char_data_o;

   typedef struct {
      logic [31:0] d;
      int          c;
   } rsp_t;

   rsp_t       exp_rq[$];
   logic [7:0] exp_cq[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         w;

   sim_mmio_console dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .char_valid_o (char_valid_o),
      .char_ready_i (char_ready_i),
      .char_data_o  (char_data_o),
      .exit_valid_o (exit_valid_o),
      .exit_code_o  (exit_code_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response and every consumed character must match the queues
   always @(negedge clk_i) begin
      if (rst_ni && rvalid_o) begin
         if (exp_rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rvalid: rdata 0x%08h at cycle %0d, expected none", rdata_o, cyc);
         end else begin
            rsp_t e;
            e = exp_rq.pop_front();
            chk("rdata", rdata_o, e.d);
            chk("rvalid_cycle", 32'(cyc), 32'(e.c));
         end
      end
      if (rst_ni && char_valid_o && char_ready_i) begin
         if (exp_cq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_char: got 0x%02h, expected none", char_data_o);
         end else begin
            logic [7:0] ec;
            ec = exp_cq.pop_front();
            chk("char_data", 32'(char_data_o), 32'(ec));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the granting edge
   task automatic bus_op(input logic [31:0] a, input logic wr, input logic [3:0] be,
                         input logic [31:0] d, input logic [31:0] exp, input int max_wait,
                         input bit exp_char, output int waited);
      req_i   = 1'b1;
      addr_i  = a;
      we_i    = wr;
      be_i    = be;
      wdata_i = d;
      waited  = 0;
      forever begin
         @(negedge clk_i);
         if (gnt_o) break;
         waited++;
         if (waited > max_wait) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: addr 0x%08h waited %0d, expected <= %0d", a, waited, max_wait);
            break;
         end
      end
      if (gnt_o) begin
         exp_rq.push_back('{d: exp, c: cyc + 1});
         if (exp_char) exp_cq.push_back(d[7:0]);
      end
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      we_i  = 1'b0;
      be_i  = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input bit ec);
      int wt;
      bus_op(a, 1'b1, be, d, 32'h0, 4, ec, wt);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      int wt;
      bus_op(a, 1'b0, 4'hF, 32'h0, exp, 4, 1'b0, wt);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_rq.size() != 0 || exp_cq.size() != 0) && k < 200) begin
         @(negedge clk_i);
         k++;
      end
      n_cmp++;
      if (k >= 200) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d responses and %0d chars outstanding, expected 0",
                  exp_rq.size(), exp_cq.size());
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_char_valid", 32'(char_valid_o), 32'h0);
      chk("rst_exit_valid", 32'(exit_valid_o), 32'h0);
      chk("rst_exit_code", exit_code_o, 32'h0);
      chk("rst_overflow", 32'(overflow_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // "Hi\n" back-to-back with consumer ready
      char_ready_i = 1'b1;
      wr(A_PUT, 4'hF, 32'h48, 1'b1);
      wr(A_PUT, 4'hF, 32'h69, 1'b1);
      wr(A_PUT, 4'hF, 32'h0A, 1'b1);
      drain();

      // Decode corners: unmapped, status write, be[0]=0 drop, low address bits
      rd(A_NONE, 32'h0);
      wr(A_NONE, 4'hF, 32'h1234, 1'b0);
      wr(A_STAT, 4'hF, 32'hFFFF_FFFF, 1'b0);
      wr(A_PUT, 4'hE, 32'h55, 1'b0);
      wr(A_PUT | 32'h3, 4'hF, 32'h5A, 1'b1);
      rd(A_TOH | 32'h2, 32'h0);
      drain();
      rd(A_STAT, 32'h0000_0001);
      drain();

      // Three queued characters, then reset with a read in flight
      char_ready_i = 1'b0;
      wr(A_PUT, 4'hF, 32'h61, 1'b1);
      wr(A_PUT, 4'hF, 32'h62, 1'b1);
      wr(A_PUT, 4'hF, 32'h63, 1'b1);
      rd(A_STAT, 32'h0000_0300);
      req_i  = 1'b1;
      addr_i = A_STAT;
      we_i   = 1'b0;
      @(negedge clk_i);
      chk("inflight_gnt", 32'(gnt_o), 32'h1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      req_i  = 1'b0;
      @(negedge clk_i);
      chk("rst_kills_rvalid", 32'(rvalid_o), 32'h0);
      chk("rst_flush_chars", 32'(char_valid_o), 32'h0);
      exp_rq.delete();
      exp_cq.delete();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      chk("post_rst_char_valid", 32'(char_valid_o), 32'h0);
      rd(A_STAT, 32'h0000_0001);
      drain();

      // Fill 16 entries, 17th stalls until one pop
      for (int i = 0; i < 16; i++) begin
         bus_op(A_PUT, 1'b1, 4'hF, 32'(8'h41 + i), 32'h0, 4, 1'b1, w);
         chk("fill_wait", 32'(w), 32'h0);
      end
      req_i   = 1'b1;
      addr_i  = A_PUT;
      we_i    = 1'b1;
      be_i    = 4'hF;
      wdata_i = 32'h51;
      @(negedge clk_i);
      chk("full_stall_gnt", 32'(gnt_o), 32'h0);
      @(posedge clk_i);
      #1;
      char_ready_i = 1'b1;
      @(negedge clk_i);
      chk("same_cycle_pop_gnt", 32'(gnt_o), 32'h0);
      @(posedge clk_i);
      #1;
      char_ready_i = 1'b0;
      @(negedge clk_i);
      chk("after_pop_gnt", 32'(gnt_o), 32'h1);
      if (gnt_o) begin
         exp_rq.push_back('{d: 32'h0, c: cyc + 1});
         exp_cq.push_back(8'h51);
      end
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      we_i  = 1'b0;
      be_i  = '0;

      // Stall timeout: granted on the 65th refused cycle and dropped
      bus_op(A_PUT, 1'b1, 4'hF, 32'h52, 32'h0, 80, 1'b0, w);
      chk("timeout_wait", 32'(w), 32'd64);
      chk("overflow_set", 32'(overflow_o), 32'h1);
      rd(A_STAT, 32'h0000_100A);
      char_ready_i = 1'b1;
      drain();
      chk("drained_char_valid", 32'(char_valid_o), 32'h0);

      // Exit latch: partial byte enables ignored, first exit wins
      wr(A_TOH, 4'h1, 32'h77, 1'b0);
      rd(A_TOH, 32'h0);
      chk("exit_be_ignored", 32'(exit_valid_o), 32'h0);
      wr(A_TOH, 4'hF, 32'h0, 1'b0);
      chk("exit_valid_set", 32'(exit_valid_o), 32'h1);
      wr(A_TOH, 4'hF, 32'h5, 1'b0);
      rd(A_TOH, 32'h0);
      chk("exit_first_wins", exit_code_o, 32'h0);
      rd(A_STAT, 32'h0000_000D);
      drain();

      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      chk("rst_clears_overflow", 32'(overflow_o), 32'h0);
      wr(A_TOH, 4'hF, 32'hDEAD_BEEF, 1'b0);
      wr(A_TOH, 4'hF, 32'h5, 1'b0);
      rd(A_TOH, 32'hDEAD_BEEF);
      chk("exit_code_kept", exit_code_o, 32'hDEAD_BEEF);
      rd(A_STAT, 32'h0000_0005);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sim_mmio_console.md
SIM_MMIO_CONSOLE -- requirements
Module: sim_mmio_console

Interface
REQ-001 SHALL have parameter PUTCHAR_ADDR, default 32'h0000_1000, word address of the character-output register.
REQ-002 SHALL have parameter TOHOST_ADDR, default 32'h0000_1004, word address of the exit-code register.
REQ-003 SHALL have parameter STATUS_ADDR, default 32'h0000_1008, word address of the read-only status register.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, character FIFO entries (power of two, at least 2).
REQ-005 Ports, in this order; one clock, reset asynchronous active-low:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  1  data request from core
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- gnt_o  out  1  request granted
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- char_valid_o  out  1  FIFO head valid
- char_ready_i  in  1  consumer accepts head
- char_data_o  out  8  FIFO head character
- exit_valid_o  out  1  exit code latched (sticky)
- exit_code_o  out  32  latched exit code
- overflow_o  out  1  sticky: putchar write dropped

Function
REQ-006 Address decode SHALL compare addr_i[31:2] with the parameter [31:2]; addr_i[1:0] is ignored.
REQ-007 gnt_o SHALL be combinational: equal to req_i, except 0 for a write to PUTCHAR_ADDR while the FIFO is full (registered full flag only; a same-cycle pop does not lift the stall).
REQ-008 Each granted request SHALL produce exactly one rvalid_o pulse on the next cycle; back-to-back grants SHALL give back-to-back rvalid_o.
REQ-009 rdata_o SHALL be registered with rvalid_o: STATUS_ADDR read = {16'b0, count[7:0], 4'b0, overflow, exit_valid, full, empty}; TOHOST_ADDR read = exit_code_o; any other read = 0; writes return 0.
REQ-010 A granted write to PUTCHAR_ADDR with be_i[0]=1 SHALL push wdata_i[7:0]; with be_i[0]=0 it SHALL be granted and dropped.
REQ-011 A PUTCHAR write stalled for more than 64 consecutive cycles SHALL be granted, dropped, and SHALL set overflow_o.
REQ-012 A granted write to TOHOST_ADDR with be_i=4'hF SHALL latch wdata_i into exit_code_o and set exit_valid_o on the next edge, but only if exit_valid_o is 0 (first exit wins); other be_i values are ignored.
REQ-013 Writes to STATUS_ADDR and to unmapped addresses SHALL be granted and ignored.
REQ-014 FIFO SHALL be first-in first-out; char_valid_o = !empty; pop occurs when char_valid_o and char_ready_i are both 1.
REQ-015 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 count SHALL be clog2(FIFO_DEPTH+1) bits wide, saturated into the 8-bit status field.
REQ-017 Stall state machine states: IDLE and STALL. IDLE->STALL on a PUTCHAR write with full; STALL->IDLE when that write is granted (not full) or on timeout (REQ-011). The stall counter SHALL clear in IDLE.

Reset
REQ-018 On rst_ni=0, asynchronously: FIFO empty, pointers 0, gnt path idle, rvalid_o=0, rdata_o=0, char_valid_o=0, exit_valid_o=0, exit_code_o=0, overflow_o=0, state=IDLE.
REQ-019 Reset mid-transaction SHALL discard any pending rvalid and all queued characters; no response SHALL follow reset deassertion.

Structure
REQ-020 Package sim_mmio_pkg SHALL hold the default address constants, the status bit-position localparams and the stall-state enum typedef.
REQ-021 The FIFO SHALL be a sub-module, sim_mmio_fifo (parameters DEPTH and WIDTH; push/pop/full/empty/count).

Verification
REQ-022 Write 'H','i','\n' to PUTCHAR with char_ready_i=1 -> char_data_o sequence 0x48, 0x69, 0x0A; each rvalid_o one cycle after its gnt_o.
REQ-023 char_ready_i=0, 17 PUTCHAR writes (DEPTH 16) -> 16 granted, 17th gnt_o=0; raise ready one cycle -> 17th granted the cycle after the pop; no data lost.
REQ-024 Hold char_ready_i=0 with FIFO full and PUTCHAR request pending for 70 cycles -> grant at the 65th stalled cycle, overflow_o=1, count stays 16.
REQ-025 TOHOST write 0x0000_0000 with be_i=4'hF, then 0x0000_0005 -> exit_valid_o=1, exit_code_o stays 0; TOHOST write with be_i=4'h1 before that -> ignored.
REQ-026 Three queued characters, read STATUS -> rdata_o = 0x0000_0300; assert rst_ni low for 1 cycle -> char_valid_o=0, STATUS read after reset = 0x0000_0001.
